// File: rtl/sec_report_sched_pkg.sv
// Shared types and constants for the PPS seconds report scheduler.
// Holds the FSM state encoding, ASCII codes, widths and one double-dabble step.
// Imported by the converter, the top level and the testbench.
package sec_report_pkg;

  localparam int SEC_W      = 16;
  localparam int BCD_DIGITS = 5;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    SEND,
    CR,
    LF
  } state_t;

  // One double-dabble iteration: add 3 to every nibble >= 5, then shift the
  // next binary bit in at the bottom.
  function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] bcd,
                                               input logic             bin_msb);
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    return {adj[BCD_W-2:0], bin_msb};
  endfunction

endpackage

// File: rtl/sec_report_sched_if.sv
// Byte-stream valid/ready link from the report scheduler to the UART TX.
// Ports: tx_data (ASCII byte), tx_valid (byte offered), tx_ready (byte taken).
// master = byte producer (scheduler), slave = byte consumer (UART TX).
interface sec_report_sched_if;
  import sec_report_pkg::*;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/sec_report_sched_bin2bcd_seq.sv
// Iterative 16-bit binary to 5-digit BCD converter (double-dabble).
// Ports: start/bin load a value; bcd holds the result, done pulses one cycle.
// Latency: 16 cycles from start to done; no backpressure, start is ignored-free.
import sec_report_pkg::*;

module bin2bcd_seq (
  input  logic             clk_50m,
  input  logic             reset_n,
  input  logic             start,
  input  logic [SEC_W-1:0] bin,
  output logic [BCD_W-1:0] bcd,
  output logic             done
);

  logic [BCD_W-1:0] bcd_q;
  logic [SEC_W-1:0] bin_q;
  logic [3:0]       cnt_q;
  logic             done_q;

  // The load cycle already performs the first shift, so the remaining 15
  // shifts finish exactly 16 cycles after start and done lines up with the
  // final value being visible on bcd.
  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      bcd_q  <= '0;
      bin_q  <= '0;
      cnt_q  <= 4'd0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        bcd_q <= dd_step('0, bin[SEC_W-1]);
        bin_q <= {bin[SEC_W-2:0], 1'b0};
        cnt_q <= 4'd15;
      end else if (cnt_q != 4'd0) begin
        bcd_q  <= dd_step(bcd_q, bin_q[SEC_W-1]);
        bin_q  <= {bin_q[SEC_W-2:0], 1'b0};
        cnt_q  <= cnt_q - 4'd1;
        done_q <= (cnt_q == 4'd1);
      end
    end
  end

  assign bcd  = bcd_q;
  assign done = done_q;

endmodule

// File: rtl/sec_report_sched.sv
// PPS-triggered ASCII seconds reporter: snapshot, convert, send digits + CR/LF.
// Ports: clk_50m/reset_n, en/second/pps from the timer, tx byte stream,
// busy/overrun/frame_done status. First byte D+17 after the PPS edge cycle D;
// bytes hold until tx_ready, PPS edges while busy are dropped and flagged.
import sec_report_pkg::*;

module sec_report_sched #(
  parameter logic LEADING_ZERO = 1'b0,
  parameter logic SEND_CRLF    = 1'b1
) (
  input  logic                      clk_50m,
  input  logic                      reset_n,
  input  logic                      en,
  input  logic [SEC_W-1:0]          second,
  input  logic                      pps,
  sec_report_sched_if.master        tx,
  output logic                      busy,
  output logic                      overrun,
  output logic                      frame_done
);

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic             pps_d_q;
  logic             overrun_q;
  logic             frame_done_q, frame_done_d;
  logic             edge_det;
  logic             conv_start;
  logic             conv_done;
  logic             xfer;
  logic [BCD_W-1:0] bcd;
  logic [3:0]       cur_digit;

  assign edge_det   = pps & ~pps_d_q;
  assign busy       = (state_q != IDLE);
  assign conv_start = edge_det & en & ~busy;
  assign xfer       = tx.tx_valid & tx.tx_ready;
  assign cur_digit  = bcd[{idx_q, 2'b00} +: 4];

  // The converter's input register is the snapshot of second: it is loaded
  // only in the detection cycle, so later changes on second have no effect.
  bin2bcd_seq u_bin2bcd (
    .clk_50m (clk_50m),
    .reset_n (reset_n),
    .start   (conv_start),
    .bin     (second),
    .bcd     (bcd),
    .done    (conv_done)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;
    tx.tx_valid  = 1'b0;
    tx.tx_data   = 8'h00;
    case (state_q)
      IDLE: begin
        if (conv_start) state_d = CONV;
      end
      CONV: begin
        if (conv_done) begin
          state_d = SEND;
          idx_d   = 3'(BCD_DIGITS - 1);
          // Start at the highest non-zero digit; digit 0 is always sent.
          if (!LEADING_ZERO) begin
            idx_d = 3'd0;
            for (int i = 1; i < BCD_DIGITS; i++) begin
              if (bcd[4*i +: 4] != 4'd0) idx_d = 3'(i);
            end
          end
        end
      end
      SEND: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = ASCII_0 + {4'h0, cur_digit};
        if (xfer) begin
          if (idx_q != 3'd0) begin
            idx_d = idx_q - 3'd1;
          end else if (SEND_CRLF) begin
            state_d = CR;
          end else begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
          end
        end
      end
      CR: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = ASCII_CR;
        if (xfer) state_d = LF;
      end
      LF: begin
        tx.tx_valid = 1'b1;
        tx.tx_data  = ASCII_LF;
        if (xfer) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50m or negedge reset_n) begin
    if (!reset_n) begin
      pps_d_q      <= 1'b0;
      state_q      <= IDLE;
      idx_q        <= 3'd0;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      pps_d_q      <= pps;
      state_q      <= state_d;
      idx_q        <= idx_d;
      // An edge on the final-transfer cycle still sees a non-idle state and
      // is reported as an overrun rather than starting a new frame.
      overrun_q    <= edge_det & busy;
      frame_done_q <= frame_done_d;
    end
  end

  assign overrun    = overrun_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sec_report_sched.sv
// Directed bench for sec_report_sched: two instances (leading zeros suppressed
// and kept) share stimulus; every expected byte is queued when a PPS is
// issued and popped when the matching DUT transfers a byte.
module tb_sec_report_sched;
  import sec_report_pkg::*;

  logic        clk_50m = 1'b0;
  logic        reset_n = 1'b0;
  logic        en      = 1'b0;
  logic        pps     = 1'b0;
  logic [15:0] second  = 16'd0;
  logic        tx_ready = 1'b0;

  logic busy0, ovr0, fd0, busy1, ovr1, fd1;

  int tests = 0;
  int fails = 0;
  int fd0_cnt = 0, fd1_cnt = 0, ovr0_cnt = 0, ovr1_cnt = 0;
  int pps_cnt = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] exp0, exp1;

  always #10 clk_50m = ~clk_50m;

  sec_report_sched_if if0 ();
  sec_report_sched_if if1 ();
  assign if0.tx_ready = tx_ready;
  assign if1.tx_ready = tx_ready;

  sec_report_sched #(.LEADING_ZERO(1'b0), .SEND_CRLF(1'b1)) dut0 (
    .clk_50m(clk_50m), .reset_n(reset_n), .en(en), .second(second), .pps(pps),
    .tx(if0), .busy(busy0), .overrun(ovr0), .frame_done(fd0)
  );

  sec_report_sched #(.LEADING_ZERO(1'b1), .SEND_CRLF(1'b1)) dut1 (
    .clk_50m(clk_50m), .reset_n(reset_n), .en(en), .second(second), .pps(pps),
    .tx(if1), .busy(busy1), .overrun(ovr1), .frame_done(fd1)
  );

  // Byte scoreboards and status pulse counters, sampled mid-cycle.
  always @(negedge clk_50m) begin
    if (reset_n && if0.tx_valid && tx_ready) begin
      if (q0.size() > 0) exp0 = q0.pop_front();
      else exp0 = 8'hxx;
      tests++;
      assert (if0.tx_data === exp0) else begin
        fails++;
        $error("FAIL byte_lz0: observed %02h expected %02h", if0.tx_data, exp0);
      end
    end
    if (reset_n && if1.tx_valid && tx_ready) begin
      if (q1.size() > 0) exp1 = q1.pop_front();
      else exp1 = 8'hxx;
      tests++;
      assert (if1.tx_data === exp1) else begin
        fails++;
        $error("FAIL byte_lz1: observed %02h expected %02h", if1.tx_data, exp1);
      end
    end
    if (fd0)  fd0_cnt++;
    if (fd1)  fd1_cnt++;
    if (ovr0) ovr0_cnt++;
    if (ovr1) ovr1_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected frame for both instances from the decimal value.
  task automatic push_frame(input int v);
    int d[5];
    int tmp;
    int top;
    tmp = v;
    for (int i = 0; i < 5; i++) begin
      d[i] = tmp % 10;
      tmp  = tmp / 10;
    end
    top = 0;
    for (int i = 1; i < 5; i++) if (d[i] != 0) top = i;
    for (int i = top; i >= 0; i--) q0.push_back(8'(48 + d[i]));
    for (int i = 4; i >= 0; i--) q1.push_back(8'(48 + d[i]));
    q0.push_back(8'h0D); q0.push_back(8'h0A);
    q1.push_back(8'h0D); q1.push_back(8'h0A);
  endtask

  // Advance one cycle; inputs change 1 time unit after the rising edge.
  // Once the PPS pulse ends, second is scrambled to prove the snapshot is used.
  task automatic step();
    @(posedge clk_50m);
    #1;
    if (pps_cnt > 0) begin
      pps_cnt--;
      if (pps_cnt == 0) begin
        pps    = 1'b0;
        second = 16'($urandom);
      end
    end
  endtask

  task automatic pps_pulse(input logic [15:0] v, input bit push);
    second  = v;
    pps     = 1'b1;
    pps_cnt = 3;
    if (push) push_frame(int'(v));
  endtask

  task automatic wait_idle();
    int n;
    step();
    step();
    n = 0;
    while ((busy0 || busy1) && n < 300) begin
      step();
      n++;
    end
    check("idle_timeout", 32'(busy0 | busy1), 32'd0);
    step();
  endtask

  task automatic check_queues(input string tag);
    check({tag, "_q0_left"}, q0.size(), 32'd0);
    check({tag, "_q1_left"}, q1.size(), 32'd0);
  endtask

  initial begin
    int f0, f1, o0, o1, vcnt;
    int vals[4];

    // Reset state.
    repeat (3) step();
    check("rst_tx_valid",   32'(if0.tx_valid), 32'd0);
    check("rst_tx_data",    32'(if0.tx_data),  32'd0);
    check("rst_busy",       32'(busy0),        32'd0);
    check("rst_overrun",    32'(ovr0),         32'd0);
    check("rst_frame_done", 32'(fd0),          32'd0);
    reset_n = 1'b1;
    step();
    en       = 1'b1;
    tx_ready = 1'b1;

    // second = 0: single '0' digit, first valid exactly at D+17.
    f0 = fd0_cnt;
    pps_pulse(16'd0, 1'b1);
    repeat (16) step();
    @(negedge clk_50m);
    check("lat_d16_valid", 32'(if0.tx_valid), 32'd0);
    step();
    @(negedge clk_50m);
    check("lat_d17_valid", 32'(if0.tx_valid), 32'd1);
    wait_idle();
    repeat (3) step();
    check("zero_frame_done", fd0_cnt - f0, 32'd1);
    check_queues("zero");

    // 65535: all seven bytes on consecutive cycles D+17..D+23.
    pps_pulse(16'd65535, 1'b1);
    repeat (24) step();
    check("max_consecutive", q0.size(), 32'd0);
    wait_idle();
    check_queues("max");

    // Leading-zero handling, inner zeros kept.
    vals = '{42, 100, 10000, 9};
    for (int k = 0; k < 4; k++) begin
      pps_pulse(16'(vals[k]), 1'b1);
      wait_idle();
      check_queues("digits");
    end

    // Backpressure: 20-cycle stall mid-frame, then random ready.
    pps_pulse(16'd12345, 1'b1);
    repeat (19) step();
    tx_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_50m);
      check("stall_valid0", 32'(if0.tx_valid), 32'd1);
      check("stall_data0",  32'(if0.tx_data),  32'(q0[0]));
      check("stall_data1",  32'(if1.tx_data),  32'(q1[0]));
      step();
    end
    for (int k = 0; k < 40; k++) begin
      tx_ready = 1'($urandom_range(0, 1));
      step();
    end
    tx_ready = 1'b1;
    wait_idle();
    check_queues("stall");

    // Overrun: second PPS while held in SEND is dropped and flagged once.
    o0 = ovr0_cnt;
    o1 = ovr1_cnt;
    tx_ready = 1'b0;
    pps_pulse(16'd7, 1'b1);
    repeat (17) step();
    pps_pulse(16'd8, 1'b0);
    repeat (6) step();
    check("ovr_pulse0", ovr0_cnt - o0, 32'd1);
    check("ovr_pulse1", ovr1_cnt - o1, 32'd1);
    tx_ready = 1'b1;
    wait_idle();
    check_queues("ovr");
    pps_pulse(16'd9, 1'b1);
    wait_idle();
    check_queues("after_ovr");

    // en = 0 at the edge: no frame and no overrun.
    en = 1'b0;
    o0 = ovr0_cnt;
    vcnt = 0;
    pps_pulse(16'd5, 1'b0);
    for (int k = 0; k < 25; k++) begin
      step();
      if (if0.tx_valid || if1.tx_valid || busy0) vcnt++;
    end
    check("en0_no_activity", vcnt, 32'd0);
    check("en0_no_overrun",  ovr0_cnt - o0, 32'd0);
    en = 1'b1;

    // Reset mid-SEND aborts immediately; next PPS gives a clean frame.
    tx_ready = 1'b0;
    pps_pulse(16'd321, 1'b1);
    repeat (18) step();
    check("pre_rst_valid", 32'(if0.tx_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check("midrst_valid", 32'(if0.tx_valid | if1.tx_valid), 32'd0);
    check("midrst_data",  32'(if0.tx_data),  32'd0);
    check("midrst_busy",  32'(busy0 | busy1), 32'd0);
    q0.delete();
    q1.delete();
    repeat (2) step();
    reset_n = 1'b1;
    step();
    tx_ready = 1'b1;
    f0 = fd0_cnt;
    f1 = fd1_cnt;
    pps_pulse(16'd654, 1'b1);
    wait_idle();
    check("post_rst_fd0", fd0_cnt - f0, 32'd1);
    check("post_rst_fd1", fd1_cnt - f1, 32'd1);
    check_queues("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sec_report_sched.md
Name: sec_report_sched

Overview:
Controller that turns each PPS tick from the seconds timer into an ASCII report line on a byte-stream UART transmitter. On every PPS rising edge it snapshots the 16-bit seconds count and converts it to decimal with an iterative converter. It then sends the digits followed by CR/LF over a valid/ready handshake. It sits between the seconds timer and the UART TX block and is the only thing that drives the TX byte stream.

Parameters:
LEADING_ZERO, 1'b0, 1 = always send 5 digits; 0 = suppress leading zeros (at least one digit is always sent)
SEND_CRLF, 1'b1, 1 = append 0x0D then 0x0A after the digits; 0 = digits only

Ports:
clk_50m  input  1  system clock; the whole block is synchronous to it
reset_n  input  1  asynchronous active-low reset
en  input  1  report enable; sampled only at PPS edge detection
second  input  16  seconds count from the timer, valid when pps rises
pps  input  1  PPS level from the timer, multi-cycle high pulse
tx_data  output  8  ASCII byte to the UART TX
tx_valid  output  1  tx_data is valid
tx_ready  input  1  UART TX accepts the byte this cycle
busy  output  1  high whenever state != IDLE
overrun  output  1  one-cycle pulse: a PPS edge arrived while busy
frame_done  output  1  one-cycle pulse: last byte of a frame accepted

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: tx_data=0, tx_valid=0, busy=0, overrun=0, frame_done=0.
  - Internal: pps_d=0, state=IDLE, snapshot/BCD/digit index cleared.
  - Asserting reset mid-frame aborts the frame immediately. No partial continuation after release.
- Edge detect:
  - pps_d registers pps.
  - Edge = pps & ~pps_d, evaluated every cycle. The cycle where it is true is the detection cycle, D.
- States: IDLE, CONV, SEND, CR, LF.
- IDLE: on edge with en=1, latch second into the shadow register at D and go to CONV at D+1. With en=0 the edge is ignored: no overrun, stay IDLE.
- CONV:
  - Double-dabble, one shift per cycle, exactly 16 cycles.
  - Each cycle, add 3 to every BCD nibble >= 5, then shift {bcd[19:0], bin} left by 1.
  - Result is 5 BCD digits, max 65535, so no overflow.
  - After the 16th cycle go to SEND with digit index = 4 (MSD).
  - First tx_valid is high in cycle D+17.
- SEND:
  - On entry, if LEADING_ZERO=0, index skips downward past zero digits. The skip is done combinationally at the CONV->SEND transition and never skips index 0.
  - tx_data = 8'h30 + digit[index]; tx_valid=1.
  - A byte transfers in a cycle with tx_valid & tx_ready.
  - tx_data and tx_valid hold stable until the transfer; tx_valid never drops without a transfer.
  - After a transfer at index>0: index--, next byte presented the next cycle (one byte per cycle max throughput).
  - After a transfer at index 0: go to CR if SEND_CRLF=1, else IDLE.
- CR: present 8'h0D, same handshake, then go to LF.
- LF: present 8'h0A, same handshake, then go to IDLE.
- frame_done pulses in the cycle after the last byte's transfer, coincident with the return to IDLE.
- tx_valid=0 in IDLE and CONV.
- PPS edge while busy: overrun=1 for one cycle. The current frame continues unchanged, the new second is dropped, and nothing is queued.
- PPS edge in the same cycle as the final transfer: state is still non-IDLE, so it counts as overrun. The frame is dropped; at 50 MHz this cannot occur in practice.
- second changing while busy: no effect; only the shadow copy is used.
- en dropping while busy: the current frame completes.

Decomposition:
- Package sec_report_pkg:
  - state enum (IDLE, CONV, SEND, CR, LF).
  - ASCII constants: 0x30, 0x0D, 0x0A.
  - Width constants: SEC_W=16, BCD_DIGITS=5.
- Sub-module bin2bcd_seq: iterative 16-bit to 5-digit double-dabble converter.
  - Inputs: start, bin[15:0].
  - Outputs: bcd[19:0], done (1-cycle pulse).
  - Same clk_50m/reset_n, 16-cycle latency.
- Top module holds the edge detect, FSM, digit index and handshake.

Test Plan:
- second=0, LEADING_ZERO=0, tx_ready=1 -> bytes 0x30,0x0D,0x0A; first tx_valid at D+17; frame_done once.
- second=65535, tx_ready=1 -> "65535\r\n" (0x36,0x35,0x35,0x33,0x35,0x0D,0x0A) on consecutive cycles.
- second=42, LEADING_ZERO=1 -> "00042\r\n"; with LEADING_ZERO=0 -> "42\r\n"; also second=100 -> "100\r\n" (inner zeros kept).
- tx_ready random/held low 20 cycles mid-frame -> tx_data/tx_valid stable while stalled; byte sequence unchanged; no dropped or duplicated bytes.
- second pulse of pps during SEND (second=7 then 8) -> overrun pulses exactly once; output is "7\r\n" only; next PPS after IDLE reports its own value.
- en=0 at PPS edge -> no tx_valid, no overrun; reset_n low mid-SEND -> all outputs 0 immediately; next PPS gives a clean full frame.
